// File: rtl/put_get_unit_if.sv
// Bundles the issue, writeback, TX/RX stream and occupancy signals of the
// put/get unit. The unit connects through the slave modport and the
// surrounding core or bench through the master modport.
interface put_get_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int ID_W  = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            issue_valid;
    logic            issue_ready;
    logic [2:0]      issue_fn3;
    logic [XLEN-1:0] issue_rs1;
    logic [4:0]      issue_rd_addr;
    logic [ID_W-1:0] issue_id;

    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd_addr;
    logic [ID_W-1:0] wb_id;
    logic            wb_exception;
    logic [4:0]      wb_ecode;

    logic            tx_valid;
    logic            tx_ready;
    logic [XLEN-1:0] tx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [XLEN-1:0] rx_data;

    logic [CW-1:0]   tx_count;
    logic [CW-1:0]   rx_count;

    modport slave (
        input  issue_valid, issue_fn3, issue_rs1, issue_rd_addr, issue_id,
        output issue_ready,
        output wb_valid, wb_data, wb_rd_addr, wb_id, wb_exception, wb_ecode,
        input  wb_ready,
        output tx_valid, tx_data, input tx_ready,
        input  rx_valid, rx_data, output rx_ready,
        output tx_count, rx_count
    );

    modport master (
        output issue_valid, issue_fn3, issue_rs1, issue_rd_addr, issue_id,
        input  issue_ready,
        input  wb_valid, wb_data, wb_rd_addr, wb_id, wb_exception, wb_ecode,
        output wb_ready,
        input  tx_valid, tx_data, output tx_ready,
        output rx_valid, rx_data, input rx_ready,
        input  tx_count, rx_count
    );
endinterface

// File: rtl/put_get_unit.sv
// Multi-cycle responder for the custom put/get instructions (CUSTOM_T).
// put pushes rs1 into the outbound TX FIFO; get pops the inbound RX FIFO and
// returns the word on writeback. One instruction is in flight at a time.
// Optional feature macro: PUT_GET_TIMEOUT_EN -- when defined, a blocked put or
// get traps after TIMEOUT wait cycles instead of waiting forever.
module put_get_unit #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    put_get_unit_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FN3_PUT = 3'b000;
    localparam logic [2:0] FN3_GET = 3'b001;
    localparam logic [4:0] ECODE_ILLEGAL_INST    = 5'd2;
    localparam logic [4:0] ECODE_LOAD_FAULT      = 5'd5;
    localparam logic [4:0] ECODE_STORE_AMO_FAULT = 5'd7;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("put_get_unit: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT_TX, WAIT_RX, RESP} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] rs1_q;
    logic [4:0]      rd_q;
    logic [ID_W-1:0] id_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_exc_q;
    logic [4:0]      wb_ecode_q;

    logic [XLEN-1:0] tx_mem [DEPTH];
    logic [XLEN-1:0] rx_mem [DEPTH];
    logic [AW-1:0]   tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]   tx_cnt, rx_cnt;

    logic            issue_hs;
    logic            tx_full, rx_empty;
    logic            tx_push, tx_pop, rx_fill, rx_pop;
    logic [XLEN-1:0] tx_push_data;
    logic            resp_load, resp_exc;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_ecode;
    logic            timeout_hit;

    assign issue_hs = bus.issue_valid && (state == IDLE);
    // Full/empty come from registered occupancy: a same-cycle pop never
    // makes room for a push, and a same-cycle fill is never poppable.
    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign tx_pop   = bus.tx_valid && bus.tx_ready;
    assign rx_fill  = bus.rx_valid && bus.rx_ready;

`ifdef PUT_GET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

    // Wait-cycle counter: zero whenever idle, so it starts fresh on every wait entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT_TX || state == WAIT_RX) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, FIFO push/pop requests and the response to latch on RESP entry
    always_comb begin
        state_n      = state;
        tx_push      = 1'b0;
        tx_push_data = rs1_q;
        rx_pop       = 1'b0;
        resp_load    = 1'b0;
        resp_data    = '0;
        resp_exc     = 1'b0;
        resp_ecode   = '0;
        case (state)
            IDLE: begin
                if (bus.issue_valid) begin
                    case (bus.issue_fn3)
                        FN3_PUT: begin
                            tx_push_data = bus.issue_rs1;
                            if (!tx_full) begin
                                tx_push   = 1'b1;
                                resp_load = 1'b1;
                                state_n   = RESP;
                            end else begin
                                state_n = WAIT_TX;
                            end
                        end
                        FN3_GET: begin
                            if (!rx_empty) begin
                                rx_pop    = 1'b1;
                                resp_load = 1'b1;
                                resp_data = rx_mem[rx_rd];
                                state_n   = RESP;
                            end else begin
                                state_n = WAIT_RX;
                            end
                        end
                        default: begin
                            resp_load  = 1'b1;
                            resp_exc   = 1'b1;
                            resp_ecode = ECODE_ILLEGAL_INST;
                            state_n    = RESP;
                        end
                    endcase
                end
            end
            WAIT_TX: begin
                if (!tx_full) begin
                    tx_push   = 1'b1;
                    resp_load = 1'b1;
                    state_n   = RESP;
                end else if (timeout_hit) begin
                    resp_load  = 1'b1;
                    resp_exc   = 1'b1;
                    resp_ecode = ECODE_STORE_AMO_FAULT;
                    state_n    = RESP;
                end
            end
            WAIT_RX: begin
                if (!rx_empty) begin
                    rx_pop    = 1'b1;
                    resp_load = 1'b1;
                    resp_data = rx_mem[rx_rd];
                    state_n   = RESP;
                end else if (timeout_hit) begin
                    resp_load  = 1'b1;
                    resp_exc   = 1'b1;
                    resp_ecode = ECODE_LOAD_FAULT;
                    state_n    = RESP;
                end
            end
            RESP: begin
                if (bus.wb_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, issue tag capture and the writeback result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_q       <= '0;
            id_q       <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= 1'b0;
            wb_ecode_q <= '0;
        end else begin
            state <= state_n;
            if (issue_hs) begin
                rd_q <= bus.issue_rd_addr;
                id_q <= bus.issue_id;
            end
            if (resp_load) begin
                wb_data_q  <= resp_data;
                wb_exc_q   <= resp_exc;
                wb_ecode_q <= resp_ecode;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CW'(1);
            if (rx_fill) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            if (rx_fill && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
            else if (!rx_fill && rx_pop) rx_cnt <= rx_cnt - CW'(1);
        end
    end

    // Data storage: FIFO arrays and the rs1 operand held for a blocked put
    always_ff @(posedge clk) begin
        if (issue_hs) rs1_q <= bus.issue_rs1;
        if (tx_push)  tx_mem[tx_wr] <= tx_push_data;
        if (rx_fill)  rx_mem[rx_wr] <= bus.rx_data;
    end

    assign bus.issue_ready  = (state == IDLE);
    assign bus.wb_valid     = (state == RESP);
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rd_addr   = rd_q;
    assign bus.wb_id        = id_q;
    assign bus.wb_exception = wb_exc_q;
    assign bus.wb_ecode     = wb_ecode_q;
    assign bus.tx_valid     = (tx_cnt != '0);
    assign bus.tx_data      = tx_mem[tx_rd];
    assign bus.rx_ready     = (rx_cnt != CW'(DEPTH));
    assign bus.tx_count     = tx_cnt;
    assign bus.rx_count     = rx_cnt;
endmodule
